// File: rtl/req_ack_responder_pkg.sv
// Shared types and width helpers for the req/ack bus responder.
// FSM state encoding is one-hot so the state register doubles as decoded flags.
package req_ack_responder_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    WAIT = 3'b010,
    ACK  = 3'b100
  } state_e;

  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 4;
  localparam int ACK_DELAY_DEF = 2;

  // Occupancy needs one extra bit so that a completely full queue is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/req_ack_fifo.sv
// Synchronous in-order DEPTH x DATA_W queue with occupancy count.
// A push while full is accepted when a pop retires the head at the same edge.
module req_ack_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int OCC_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [OCC_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  wptr_d;
  logic [PTR_W-1:0]  rptr_q;
  logic [PTR_W-1:0]  rptr_d;
  logic [OCC_W-1:0]  count_q;
  logic [OCC_W-1:0]  count_d;
  logic              push_ok;
  logic              pop_ok;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    pop_ok  = pop_i && (count_q != {OCC_W{1'b0}});
    push_ok = push_i && ((count_q != OCC_W'(DEPTH)) || pop_ok);

    if (push_ok) begin
      wptr_d = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_ok) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end

    if (push_ok && !pop_ok) begin
      count_d = count_q + OCC_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - OCC_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
      count_q <= {OCC_W{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == OCC_W'(DEPTH));
  assign empty_o = (count_q == {OCC_W{1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/req_ack_responder.sv
// Bus-side responder: queues bus_req pulses, acks each after ACK_DELAY, forwards data on valid/ready.
// Define REQ_ACK_RESPONDER_ASSERT_EN to compile in the embedded protocol checks and covers.
module req_ack_responder
  import req_ack_responder_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ACK_DELAY = ACK_DELAY_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bus_req,
  input  logic [DATA_W-1:0]           bus_data,
  output logic                        bus_ack,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        overflow,
  output logic [occ_width(DEPTH)-1:0] pending
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam int CNT_W = $clog2(ACK_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_DELAY);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bus_ack_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              overflow_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  logic              pop;
  logic              push;
  logic              drop;
  logic              out_free;
  logic              remain;

  always_comb begin
    pop      = (state_q == ACK);
    out_free = !out_valid_q || out_ready;
    push     = bus_req && (!fifo_full || pop);
    drop     = bus_req && fifo_full && !pop;
    remain   = (fifo_count > OCC_W'(1)) || push;
  end

  req_ack_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .OCC_W  (OCC_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (bus_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // IDLE reacts to the push edge itself so the first ack lands ACK_DELAY+2 cycles after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      bus_ack_q <= 1'b0;
    end else begin
      bus_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (push || !fifo_empty) begin
            state_q <= WAIT;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if ((cnt_q == CNT_MAX) && out_free) begin
            state_q   <= ACK;
            bus_ack_q <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= WAIT;
          end
        end
        ACK: begin
          cnt_q <= {CNT_W{1'b0}};
          if (remain) begin
            state_q <= WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output register: a pop always wins, otherwise a completed handshake empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= fifo_head;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus_ack   = bus_ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign pending   = fifo_count;

`ifdef REQ_ACK_RESPONDER_ASSERT_EN
  a_no_drop: assert property (@(posedge clk) disable iff (reset) !drop)
    else $error("req_ack_responder: request dropped, queue full");
  a_ack_has_entry: assert property (@(posedge clk) disable iff (reset)
    !(bus_ack_q && (fifo_count == {OCC_W{1'b0}})))
    else $error("req_ack_responder: bus_ack with empty queue");
  a_ack_single: assert property (@(posedge clk) disable iff (reset) bus_ack_q |=> !bus_ack_q)
    else $error("req_ack_responder: bus_ack high two cycles in a row");
  a_state_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(state_q))
    else $error("req_ack_responder: FSM state not one-hot");
  c_queue_full: cover property (@(posedge clk) disable iff (reset) fifo_full);
  c_output_stall: cover property (@(posedge clk) disable iff (reset) out_valid_q && !out_ready);
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Self-checking bench for req_ack_responder: cycle table for latency/spacing, scoreboard for data order.
module tb_req_ack_responder;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int ACK_DELAY = 2;
  localparam int OCC_W     = 3;
  localparam int NV        = 27;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              bus_req = 1'b0;
  logic [DATA_W-1:0] bus_data = '0;
  logic              out_ready = 1'b1;
  logic              bus_ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              overflow;
  logic [OCC_W-1:0]  pending;

  int n_chk = 0;
  int n_err = 0;
  int n_ack = 0;
  logic prev_ack = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic              req;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              ack;
    logic              valid;
    logic [OCC_W-1:0]  pend;
    logic              ovf;
  } vec_t;

  vec_t vec [NV];

  always #5 clk = ~clk;

  req_ack_responder #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ACK_DELAY (ACK_DELAY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_req   (bus_req),
    .bus_data  (bus_data),
    .bus_ack   (bus_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .pending   (pending)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs applied just after the edge, outputs readable on return.
  task automatic cyc_go(input logic req, input logic [DATA_W-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    bus_req   = req;
    bus_data  = d;
    out_ready = rdy;
    #3;
  endtask

  // Scoreboard monitor: pops expected data on each handshake and watches ack pulses.
  always @(negedge clk) begin
    logic [DATA_W-1:0] e;
    if (reset !== 1'b0) begin
      prev_ack = 1'b0;
    end else begin
      if (bus_ack === 1'b1) begin
        n_ack++;
        n_chk++;
        if (prev_ack === 1'b1) begin
          n_err++;
          $display("FAIL ack_consecutive: bus_ack high two cycles in a row (t=%0t)", $time);
        end
      end
      prev_ack = bus_ack;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: out_data %0h emitted, none expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_err++;
            $display("FAIL sb_data: got %0h, expected %0h", out_data, e);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_ack;
    int waited;

    // Cycle table: single request (rows 0-7), then four back-to-back requests (rows 8-26).
    for (int i = 0; i < NV; i++) begin
      vec[i] = '{req: 1'b0, data: '0, ready: 1'b1, ack: 1'b0, valid: 1'b0, pend: '0, ovf: 1'b0};
    end
    vec[0].req  = 1'b1;
    vec[0].data = 32'hfeed;
    for (int j = 1; j <= 4; j++) vec[j].pend = 3'd1;
    vec[4].ack   = 1'b1;
    vec[5].valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vec[8 + k].req  = 1'b1;
      vec[8 + k].data = 32'(k + 1);
    end
    for (int j = 1; j <= 4; j++)   vec[8 + j].pend = 3'(j);
    for (int j = 5; j <= 8; j++)   vec[8 + j].pend = 3'd3;
    for (int j = 9; j <= 12; j++)  vec[8 + j].pend = 3'd2;
    for (int j = 13; j <= 16; j++) vec[8 + j].pend = 3'd1;
    for (int m = 0; m < 4; m++) begin
      vec[8 + 4 + 4 * m].ack   = 1'b1;
      vec[8 + 5 + 4 * m].valid = 1'b1;
    end

    reset = 1'b1;
    cyc_go(1'b0, '0, 1'b1);
    cyc_go(1'b0, '0, 1'b1);
    chk("rst_ack", bus_ack, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_pend", pending, 3'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cyc_go(vec[i].req, vec[i].data, vec[i].ready);
      if (vec[i].req) exp_q.push_back(vec[i].data);
      chk($sformatf("row%0d_ack", i), bus_ack, vec[i].ack);
      chk($sformatf("row%0d_valid", i), out_valid, vec[i].valid);
      chk($sformatf("row%0d_pend", i), pending, vec[i].pend);
      chk($sformatf("row%0d_ovf", i), overflow, vec[i].ovf);
    end
    chk("tblAB_sb_empty", exp_q.size(), 0);

    // Stalled output: six requests; the fifth lands in the ACK cycle while full, the sixth drops.
    base_ack = n_ack;
    for (int k = 0; k < 6; k++) begin
      cyc_go(1'b1, 32'(k + 1), 1'b0);
      if (k < 5) exp_q.push_back(32'(k + 1));
      if (k == 4) begin
        chk("full_ack_cycle_ack", bus_ack, 1'b1);
        chk("full_ack_cycle_pend", pending, 3'd4);
      end
      if (k == 5) begin
        chk("after_ack_push_pend", pending, 3'd4);
        chk("after_ack_push_ovf", overflow, 1'b0);
        chk("after_ack_valid", out_valid, 1'b1);
        chk("after_ack_data", out_data, 32'd1);
      end
    end
    for (int k = 0; k < 5; k++) begin
      cyc_go(1'b0, '0, 1'b0);
      chk("stall_ovf", overflow, 1'b1);
      chk("stall_pend", pending, 3'd4);
      chk("stall_ack", bus_ack, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data_hold", out_data, 32'd1);
    end
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      cyc_go(1'b0, '0, 1'b1);
      waited++;
    end
    chk("drain_sb_empty", exp_q.size(), 0);
    cyc_go(1'b0, '0, 1'b1);
    chk("drain_ovf_sticky", overflow, 1'b1);
    chk("drain_pend", pending, 3'd0);
    chk("drain_ack_count", n_ack - base_ack, 5);

    // Reset with three queued entries and a held output discards everything.
    for (int k = 0; k < 4; k++) begin
      cyc_go(1'b1, 32'(21 + k), 1'b0);
    end
    cyc_go(1'b0, '0, 1'b0);
    chk("pre_rst_ack", bus_ack, 1'b1);
    chk("pre_rst_pend4", pending, 3'd4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #3;
    exp_q.delete();
    chk("pre_rst_pend3", pending, 3'd3);
    chk("pre_rst_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
    chk("post_rst_ack", bus_ack, 1'b0);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_data", out_data, 32'h0);
    chk("post_rst_ovf", overflow, 1'b0);
    chk("post_rst_pend", pending, 3'd0);
    base_ack = n_ack;
    for (int k = 0; k < 8; k++) begin
      cyc_go(1'b0, '0, 1'b1);
      chk("post_rst_idle_ack", bus_ack, 1'b0);
    end
    chk("post_rst_no_acks", n_ack - base_ack, 0);

    for (int k = 0; k < 7; k++) begin
      cyc_go((k == 0), 32'h5a5a, 1'b1);
      if (k == 0) exp_q.push_back(32'h5a5a);
      chk($sformatf("relat_ack_c%0d", k), bus_ack, (k == 4));
      chk($sformatf("relat_valid_c%0d", k), out_valid, (k == 5));
      if (k == 5) chk("relat_data", out_data, 32'h5a5a);
    end
    chk("relat_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
